ts_tx_sched: RTL and testbench

- Transmit-side ordered-set scheduler for the LTSSM model; the counterpart of the receive-side TS analyzer.
- On each LTSSM (sub)state change it sequences a continuous stream of TS1/TS2 ordered sets into the TS TX FIFO, honouring FIFO backpressure.
- Periodically arbitrates SKP ordered sets into the same FIFO slot.
- Counts TS sent and raises ts_sent_enough when the per-substate quota is met.

---
 rtl/ts_tx_sched.sv | 188 ++++++++++++++++++
 tb/tb_ts_tx_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ts_tx_sched.sv
// ts_tx_sched: transmit-side TS1/TS2 ordered-set scheduler for the LTSSM model.
// Streams TS words into the TS TX FIFO for the active (sub)state job, honours
// FIFO backpressure, counts TS words sent and flags when the quota is met.
// Optional SKP insertion is enabled by defining TS_TX_SCHED_SKP_EN.
module ts_tx_sched #(
  parameter int CNT_W      = 11,
  parameter int SKP_INT_G1 = 8,
  parameter int SKP_INT_G2 = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ts_info,
  input  logic             ts_update,
  input  logic             ts_stop,
  input  logic             speed,
  input  logic             ts_type,
  input  logic [CNT_W-1:0] ts_tgt_cnt,
  input  logic [7:0]       link_num,
  input  logic [7:0]       lane_num,
  input  logic [7:0]       train_ctl,
  input  logic             ts_tx_fifo_full,
  output logic             ts_tx_wr,
  output logic [127:0]     ts_tx_data,
  output logic             ts_sent_enough,
  output logic [CNT_W-1:0] ts_sent_cnt,
  output logic [7:0]       ts_cur_info,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A zero SKP interval has no meaningful schedule; this block only exists
  // to make such a configuration visible in the elaborated hierarchy.
  if (SKP_INT_G1 < 1 || SKP_INT_G2 < 1) begin : g_bad_skp_interval
  end

`ifdef TS_TX_SCHED_SKP_EN
  typedef enum logic [1:0] {IDLE, SEND, SKP} state_t;
  localparam logic [127:0] SKP_WORD = {96'h0, 24'h1C1C1C, 8'hBC};
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif

  state_t           state_q, state_d;
  logic [7:0]       info_q, info_d;
  logic             type_q, type_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [7:0]       link_q, link_d;
  logic [7:0]       lane_q, lane_d;
  logic [7:0]       ctl_q, ctl_d;
  logic             wr_q, wr_d;
  logic [127:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enough_q, enough_d;
  logic             do_ts;
`ifdef TS_TX_SCHED_SKP_EN
  logic [CNT_W-1:0] skp_q, skp_d;
  logic [CNT_W-1:0] skp_nxt;
  logic [CNT_W-1:0] skp_int;
`endif

  // Builds a TS1/TS2 word from the job fields and the current link speed.
  function automatic logic [127:0] ts_word(input logic [7:0] link,
                                           input logic [7:0] lane,
                                           input logic [7:0] ctl,
                                           input logic       typ,
                                           input logic       spd);
    logic [7:0] id;
    logic [7:0] rate;
    id   = typ ? 8'h45 : 8'h4A;
    rate = spd ? 8'h06 : 8'h02;
    return {{10{id}}, ctl, rate, 8'h00, lane, link, 8'hBC};
  endfunction

  // Next-state and registered-output decisions for the scheduler.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    info_d   = info_q;
    type_d   = type_q;
    tgt_d    = tgt_q;
    link_d   = link_q;
    lane_d   = lane_q;
    ctl_d    = ctl_q;
    wr_d     = 1'b0;
    data_d   = data_q;
    cnt_d    = cnt_q;
    enough_d = enough_q | ((state_q != IDLE) && (cnt_q >= tgt_q));
    do_ts    = 1'b0;
`ifdef TS_TX_SCHED_SKP_EN
    skp_d    = skp_q;
    skp_nxt  = '0;
    skp_int  = speed ? CNT_W'(SKP_INT_G2) : CNT_W'(SKP_INT_G1);
`endif

    if (ts_stop) begin
      // Stop wins over a coincident update; counters and flags hold.
      state_d = IDLE;
    end else if (ts_update) begin
      info_d   = ts_info;
      type_d   = ts_type;
      tgt_d    = ts_tgt_cnt;
      link_d   = link_num;
      lane_d   = lane_num;
      ctl_d    = train_ctl;
      cnt_d    = '0;
      enough_d = (ts_tgt_cnt == '0);
      state_d  = SEND;
      do_ts    = !ts_tx_fifo_full;
`ifdef TS_TX_SCHED_SKP_EN
      skp_d    = '0;
`endif
    end else begin
      case (state_q)
        SEND: do_ts = !ts_tx_fifo_full;
`ifdef TS_TX_SCHED_SKP_EN
        SKP: begin
          if (!ts_tx_fifo_full) begin
            wr_d    = 1'b1;
            data_d  = SKP_WORD;
            state_d = SEND;
          end
        end
`endif
        default: ;
      endcase
    end

    if (do_ts) begin
      wr_d   = 1'b1;
      data_d = ts_word(link_d, lane_d, ctl_d, type_d, speed);
      if (cnt_d != '1) cnt_d = cnt_d + CNT_ONE;
`ifdef TS_TX_SCHED_SKP_EN
      skp_nxt = skp_d + CNT_ONE;
      if (skp_nxt >= skp_int) begin
        state_d = SKP;
        skp_d   = '0;
      end else begin
        skp_d = skp_nxt;
      end
`endif
    end
  end

  // State, latched job fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      info_q   <= '0;
      type_q   <= 1'b0;
      tgt_q    <= '0;
      link_q   <= '0;
      lane_q   <= '0;
      ctl_q    <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
      enough_q <= 1'b0;
`ifdef TS_TX_SCHED_SKP_EN
      skp_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      info_q   <= info_d;
      type_q   <= type_d;
      tgt_q    <= tgt_d;
      link_q   <= link_d;
      lane_q   <= lane_d;
      ctl_q    <= ctl_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      enough_q <= enough_d;
`ifdef TS_TX_SCHED_SKP_EN
      skp_q    <= skp_d;
`endif
    end
  end

  assign ts_tx_wr       = wr_q;
  assign ts_tx_data     = data_q;
  assign ts_sent_enough = enough_q;
  assign ts_sent_cnt    = cnt_q;
  assign ts_cur_info    = info_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ts_tx_sched.sv
// tb_ts_tx_sched: directed self-checking bench for ts_tx_sched.
// SKP expectations follow TS_TX_SCHED_SKP_EN, matching the RTL build.
module tb_ts_tx_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   ts_info;
  logic         ts_update;
  logic         ts_stop;
  logic         speed;
  logic         ts_type;
  logic [10:0]  ts_tgt_cnt;
  logic [7:0]   link_num;
  logic [7:0]   lane_num;
  logic [7:0]   train_ctl;
  logic         ts_tx_fifo_full;
  logic         ts_tx_wr;
  logic [127:0] ts_tx_data;
  logic         ts_sent_enough;
  logic [10:0]  ts_sent_cnt;
  logic [7:0]   ts_cur_info;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Hand-assembled words: id x10, ctl, rate, N_FTS, lane, link, COM.
  localparam logic [127:0] W_Q = 128'h4A4A4A4A4A4A4A4A4A4A_00_02_00_03_01_BC;
  localparam logic [127:0] W_A = 128'h4A4A4A4A4A4A4A4A4A4A_08_02_00_02_11_BC;
  localparam logic [127:0] W_B = 128'h45454545454545454545_08_02_00_02_11_BC;
  localparam logic [127:0] W_C = 128'h45454545454545454545_08_06_00_02_11_BC;
`ifdef TS_TX_SCHED_SKP_EN
  localparam logic [127:0] W_SKP = 128'h0000_0000_0000_0000_0000_0000_1C1C_1CBC;
`endif

  ts_tx_sched dut (
    .clk             (clk),
    .rst             (rst),
    .ts_info         (ts_info),
    .ts_update       (ts_update),
    .ts_stop         (ts_stop),
    .speed           (speed),
    .ts_type         (ts_type),
    .ts_tgt_cnt      (ts_tgt_cnt),
    .link_num        (link_num),
    .lane_num        (lane_num),
    .train_ctl       (train_ctl),
    .ts_tx_fifo_full (ts_tx_fifo_full),
    .ts_tx_wr        (ts_tx_wr),
    .ts_tx_data      (ts_tx_data),
    .ts_sent_enough  (ts_sent_enough),
    .ts_sent_cnt     (ts_sent_cnt),
    .ts_cur_info     (ts_cur_info),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_ts(input string tag, input logic [127:0] w, input int cnt, input logic en);
    check({tag, "_wr"},     128'(ts_tx_wr),       128'(1));
    check({tag, "_data"},   ts_tx_data,           w);
    check({tag, "_cnt"},    128'(ts_sent_cnt),    128'(cnt));
    check({tag, "_enough"}, 128'(ts_sent_enough), 128'(en));
  endtask

`ifdef TS_TX_SCHED_SKP_EN
  task automatic expect_skp(input string tag, input int cnt, input logic en);
    check({tag, "_skp_wr"},     128'(ts_tx_wr),       128'(1));
    check({tag, "_skp_data"},   ts_tx_data,           W_SKP);
    check({tag, "_skp_cnt"},    128'(ts_sent_cnt),    128'(cnt));
    check({tag, "_skp_enough"}, 128'(ts_sent_enough), 128'(en));
  endtask
`endif

  initial begin
    rst = 1'b1; ts_info = '0; ts_update = 1'b0; ts_stop = 1'b0; speed = 1'b0;
    ts_type = 1'b0; ts_tgt_cnt = '0; link_num = '0; lane_num = '0;
    train_ctl = '0; ts_tx_fifo_full = 1'b0;
    tick; tick;

    // Reset values
    check("rst_wr",     128'(ts_tx_wr),       128'(0));
    check("rst_data",   ts_tx_data,           128'h0);
    check("rst_enough", 128'(ts_sent_enough), 128'(0));
    check("rst_cnt",    128'(ts_sent_cnt),    128'(0));
    check("rst_info",   128'(ts_cur_info),    128'(0));
    check("rst_busy",   128'(busy),           128'(0));

    rst = 1'b0;
    tick; tick;
    check("idle_wr",     128'(ts_tx_wr),       128'(0));
    check("idle_busy",   128'(busy),           128'(0));
    check("idle_enough", 128'(ts_sent_enough), 128'(0));

    // Basic quota: TS1, tgt=16, FIFO never full
    ts_info = 8'h21; ts_type = 1'b0; ts_tgt_cnt = 11'd16;
    link_num = 8'h01; lane_num = 8'h03; train_ctl = 8'h00; ts_update = 1'b1;
    tick;
    ts_update = 1'b0;
    check("quota_info", 128'(ts_cur_info), 128'(8'h21));
    check("quota_busy", 128'(busy),        128'(1));
    for (int i = 1; i <= 21; i++) begin
`ifdef TS_TX_SCHED_SKP_EN
      if (i > 1 && (i - 1) % 8 == 0) begin
        expect_skp("quota", i - 1, (i - 1) >= 16);
        tick;
      end
`endif
      expect_ts("quota", W_Q, i, (i - 1) >= 16);
      if (i < 21) tick;
    end

    // Backpressure: full held for 5 cycles while TS#21 is on the bus
    ts_tx_fifo_full = 1'b1;
    tick;
    for (int k = 0; k < 5; k++) begin
      check("bp_wr",  128'(ts_tx_wr),    128'(0));
      check("bp_cnt", 128'(ts_sent_cnt), 128'(21));
      if (k == 4) ts_tx_fifo_full = 1'b0;
      tick;
    end
    expect_ts("bp_resume", W_Q, 22, 1'b1);

    // Job switch: TS1 job A at cnt=5, then TS2 job B with tgt=8
    ts_info = 8'h22; ts_tgt_cnt = 11'd100; link_num = 8'h11; lane_num = 8'h02;
    train_ctl = 8'h08; ts_update = 1'b1;
    tick;
    ts_update = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      expect_ts("jobA", W_A, i, 1'b0);
      if (i < 5) tick;
    end
    ts_info = 8'h23; ts_type = 1'b1; ts_tgt_cnt = 11'd8; ts_update = 1'b1;
    tick;
    ts_update = 1'b0;
    check("jobB_info", 128'(ts_cur_info), 128'(8'h23));
    for (int i = 1; i <= 10; i++) begin
`ifdef TS_TX_SCHED_SKP_EN
      if (i > 1 && (i - 1) % 8 == 0) begin
        expect_skp("jobB", i - 1, (i - 1) >= 8);
        tick;
      end
`endif
      expect_ts("jobB", W_B, i, (i - 1) >= 8);
      tick;
    end

    // Gen2 job with tgt=0: enough immediately, rate ID 06, 16-word SKP spacing
    speed = 1'b1; ts_info = 8'h24; ts_tgt_cnt = 11'd0; ts_update = 1'b1;
    tick;
    ts_update = 1'b0;
    for (int i = 1; i <= 18; i++) begin
`ifdef TS_TX_SCHED_SKP_EN
      if (i > 1 && (i - 1) % 16 == 0) begin
        expect_skp("jobC", i - 1, 1'b1);
        tick;
      end
`endif
      expect_ts("jobC", W_C, i, 1'b1);
      if (i < 18) tick;
    end

    // Stop/update collision: stop wins
    ts_stop = 1'b1; ts_update = 1'b1; ts_info = 8'h55;
    tick;
    ts_stop = 1'b0; ts_update = 1'b0;
    check("coll_wr",   128'(ts_tx_wr),    128'(0));
    check("coll_busy", 128'(busy),        128'(0));
    check("coll_info", 128'(ts_cur_info), 128'(8'h24));
    for (int k = 0; k < 3; k++) begin
      tick;
      check("coll_quiet_wr", 128'(ts_tx_wr), 128'(0));
    end

    // Reset mid-job (lands in SKP state when SKP insertion is built in)
    speed = 1'b0; ts_type = 1'b0; ts_info = 8'h26; ts_tgt_cnt = 11'd4;
    link_num = 8'h01; lane_num = 8'h03; train_ctl = 8'h00; ts_update = 1'b1;
    tick;
    ts_update = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      expect_ts("jobD", W_Q, i, (i - 1) >= 4);
      if (i < 8) tick;
    end
    check("jobD_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    tick;
    check("mrst_wr",     128'(ts_tx_wr),       128'(0));
    check("mrst_data",   ts_tx_data,           128'h0);
    check("mrst_enough", 128'(ts_sent_enough), 128'(0));
    check("mrst_cnt",    128'(ts_sent_cnt),    128'(0));
    check("mrst_info",   128'(ts_cur_info),    128'(0));
    check("mrst_busy",   128'(busy),           128'(0));
    rst = 1'b0;
    tick;
    check("post_rst_wr",   128'(ts_tx_wr), 128'(0));
    check("post_rst_busy", 128'(busy),     128'(0));
    tick;
    check("post_rst_wr2",  128'(ts_tx_wr), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
